// File: rtl/gps_transmitter_if.sv
// Byte-stream port bundle for the GPZDA serialiser: frame request, captured
// fields, valid/ready byte handshake and frame status.
interface gps_transmitter_if #(
    parameter int B = 8
);
    logic           start;
    logic [7*B-1:0] utc;
    logic [2*B-1:0] day;
    logic [2*B-1:0] month;
    logic [4*B-1:0] year;
    logic           busy;
    logic           valid;
    logic           ready;
    logic [B-1:0]   data;
    logic           done;
    logic           error;

    modport master (
        output start, utc, day, month, year, ready,
        input  busy, valid, data, done, error
    );

    modport slave (
        input  start, utc, day, month, year, ready,
        output busy, valid, data, done, error
    );
endinterface

// File: rtl/gps_transmitter.sv
// Serialises one captured GPZDA time/date record into an NMEA byte stream
// with optional *hh XOR checksum and CR LF terminator.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_PREFIX | "$GPZDA" + separator
// S_UTC    | 7 utc bytes + separator
// S_DAY    | 2 day digits + separator
// S_MONTH  | 2 month digits + separator
// S_YEAR   | 4 year digits
// S_ZONE   | ",00,00"
// S_CHECK  | '*' + two hex digits
// S_TAIL   | CR LF
module gps_transmitter #(
    parameter int           B         = 8,
    parameter logic [B-1:0] Separator = 8'h2C,
    parameter bit           NoCheck   = 1'b0
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    gps_transmitter_if.slave bus
);

    typedef enum logic [3:0] {
        S_IDLE, S_PREFIX, S_UTC, S_DAY, S_MONTH, S_YEAR, S_ZONE, S_CHECK, S_TAIL
    } state_t;

    localparam logic [47:0] PrefixStr = "$GPZDA";

    state_t         state_q, state_d;
    logic [2:0]     idx_q, idx_d;
    logic [B-1:0]   data_q, data_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [7:0]     chk_q, chk_d;
    logic [7*B-1:0] utc_q, utc_d;
    logic [2*B-1:0] day_q, day_d;
    logic [2*B-1:0] month_q, month_d;
    logic [4*B-1:0] year_q, year_d;
    logic           fld_err;

    function automatic logic [2:0] last_idx(input state_t st);
        case (st)
            S_PREFIX: return 3'd6;
            S_UTC:    return 3'd7;
            S_DAY:    return 3'd2;
            S_MONTH:  return 3'd2;
            S_YEAR:   return 3'd3;
            S_ZONE:   return 3'd5;
            S_CHECK:  return 3'd2;
            S_TAIL:   return 3'd1;
            default:  return 3'd0;
        endcase
    endfunction

    function automatic state_t next_state(input state_t st);
        case (st)
            S_PREFIX: return S_UTC;
            S_UTC:    return S_DAY;
            S_DAY:    return S_MONTH;
            S_MONTH:  return S_YEAR;
            S_YEAR:   return S_ZONE;
            S_ZONE:   return NoCheck ? S_TAIL : S_CHECK;
            S_CHECK:  return S_TAIL;
            default:  return S_IDLE;
        endcase
    endfunction

    function automatic logic [B-1:0] hex_digit(input logic [3:0] n);
        return (n < 4'd10) ? B'(8'h30 + {4'h0, n}) : B'(8'h37 + {4'h0, n});
    endfunction

    function automatic logic not_digit(input logic [B-1:0] c);
        return (c < B'(8'h30)) || (c > B'(8'h39));
    endfunction

    // Byte at a frame position; reads the captured fields, never the live inputs.
    function automatic logic [B-1:0] byte_at(input state_t st, input logic [2:0] ix,
                                             input logic [7:0] ck);
        case (st)
            S_PREFIX: return (ix < 3'd6) ? B'(PrefixStr[(5 - int'(ix))*8 +: 8]) : Separator;
            S_UTC:    return (ix < 3'd7) ? utc_q[(6 - int'(ix))*B +: B] : Separator;
            S_DAY:    return (ix < 3'd2) ? day_q[(1 - int'(ix))*B +: B] : Separator;
            S_MONTH:  return (ix < 3'd2) ? month_q[(1 - int'(ix))*B +: B] : Separator;
            S_YEAR:   return year_q[(3 - int'(ix))*B +: B];
            S_ZONE:   return (ix == 3'd0 || ix == 3'd3) ? Separator : B'(8'h30);
            S_CHECK:  begin
                if (ix == 3'd0)      return B'(8'h2A);
                else if (ix == 3'd1) return hex_digit(ck[7:4]);
                else                 return hex_digit(ck[3:0]);
            end
            S_TAIL:   return (ix == 3'd0) ? B'(8'h0D) : B'(8'h0A);
            default:  return '0;
        endcase
    endfunction

    always_comb begin
        fld_err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            fld_err = fld_err | not_digit(bus.day[i*B +: B]) | not_digit(bus.month[i*B +: B]);
        end
        for (int i = 0; i < 4; i++) begin
            fld_err = fld_err | not_digit(bus.year[i*B +: B]);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        chk_d   = chk_q;
        utc_d   = utc_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;

        if (state_q == S_IDLE) begin
            if (bus.start) begin
                utc_d   = bus.utc;
                day_d   = bus.day;
                month_d = bus.month;
                year_d  = bus.year;
                err_d   = fld_err;
                chk_d   = 8'h00;
                state_d = S_PREFIX;
                idx_d   = 3'd0;
                data_d  = B'(8'h24);
                valid_d = 1'b1;
                busy_d  = 1'b1;
            end
        end else if (valid_q && bus.ready) begin
            // Checksum covers everything between '$' and '*'.
            if (state_q != S_CHECK && state_q != S_TAIL &&
                !(state_q == S_PREFIX && idx_q == 3'd0)) begin
                chk_d = chk_q ^ data_q[7:0];
            end
            if (idx_q == last_idx(state_q)) begin
                state_d = next_state(state_q);
                idx_d   = 3'd0;
            end else begin
                idx_d   = idx_q + 3'd1;
            end
            if (state_q == S_TAIL && idx_q == last_idx(S_TAIL)) begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                data_d  = '0;
            end else begin
                data_d  = byte_at(state_d, idx_d, chk_d);
            end
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            chk_q   <= '0;
            utc_q   <= '0;
            day_q   <= '0;
            month_q <= '0;
            year_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            chk_q   <= chk_d;
            utc_q   <= utc_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.valid = valid_q;
    assign bus.data  = data_q;
    assign bus.done  = done_q;
    assign bus.error = err_q;

endmodule

// File: tb/tb_gps_transmitter.sv
// Scoreboard bench for gps_transmitter: one instance with checksum, one without,
// both fed the same stimulus; expected bytes are queued when a frame is started.
module tb_gps_transmitter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        ready;
    logic        rand_ready;
    logic [55:0] utc;
    logic [15:0] day, month;
    logic [31:0] year;

    int errors = 0;
    int checks = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         beats0, beats1;
    logic       hold0, hold1, dprev0, dprev1;
    logic [7:0] hdata0, hdata1;

    always #5 clock = ~clock;

    gps_transmitter_if #(.B(8)) if0 ();
    gps_transmitter_if #(.B(8)) if1 ();

    assign if0.start = start;  assign if1.start = start;
    assign if0.ready = ready;  assign if1.ready = ready;
    assign if0.utc   = utc;    assign if1.utc   = utc;
    assign if0.day   = day;    assign if1.day   = day;
    assign if0.month = month;  assign if1.month = month;
    assign if0.year  = year;   assign if1.year  = year;

    gps_transmitter #(.B(8), .NoCheck(1'b0)) dut0 (.clock_i(clock), .reset_n_i(reset_n), .bus(if0));
    gps_transmitter #(.B(8), .NoCheck(1'b1)) dut1 (.clock_i(clock), .reset_n_i(reset_n), .bus(if1));

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    task automatic push_frame();
        logic [7:0]  f[$];
        logic [47:0] p;
        logic [7:0]  ck;
        p = "$GPZDA";
        for (int i = 5; i >= 0; i--) f.push_back(p[i*8 +: 8]);
        f.push_back(8'h2C);
        for (int i = 6; i >= 0; i--) f.push_back(utc[i*8 +: 8]);
        f.push_back(8'h2C);
        f.push_back(day[15:8]);   f.push_back(day[7:0]);   f.push_back(8'h2C);
        f.push_back(month[15:8]); f.push_back(month[7:0]); f.push_back(8'h2C);
        for (int i = 3; i >= 0; i--) f.push_back(year[i*8 +: 8]);
        f.push_back(8'h2C); f.push_back(8'h30); f.push_back(8'h30);
        f.push_back(8'h2C); f.push_back(8'h30); f.push_back(8'h30);
        ck = 8'h00;
        for (int i = 1; i < f.size(); i++) ck ^= f[i];
        foreach (f[i]) begin
            q0.push_back(f[i]);
            q1.push_back(f[i]);
        end
        q0.push_back(8'h2A); q0.push_back(hexc(ck[7:4])); q0.push_back(hexc(ck[3:0]));
        q0.push_back(8'h0D); q0.push_back(8'h0A);
        q1.push_back(8'h0D); q1.push_back(8'h0A);
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic do_start(input bit expect_frame);
        tick();
        start = 1'b1;
        if (expect_frame) push_frame();
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (q0.size() == 0 && q1.size() == 0 && !if0.busy && !if1.busy) break;
            @(negedge clock);
        end
        tick();
        chk_eq("frame_drain", q0.size() + q1.size() + int'(if0.busy) + int'(if1.busy), 0);
        q0.delete();
        q1.delete();
    endtask

    task automatic wait_beats(input int n);
        for (int i = 0; i < 200 && beats0 < n; i++) @(posedge clock);
        chk_eq("beat_wait", beats0, n);
        #2;
    endtask

    always @(negedge clock) begin
        if (!reset_n) begin
            beats0 = 0; hold0 = 1'b0; dprev0 = 1'b0;
        end else begin
            if (hold0) begin
                chk_eq("d0_hold_valid", if0.valid, 1);
                chk_eq("d0_hold_data", if0.data, hdata0);
            end
            if (if0.done) begin
                chk_eq("d0_done_width", dprev0, 0);
                chk_eq("d0_frame_len", beats0, 36);
                chk_eq("d0_done_valid", if0.valid, 0);
                chk_eq("d0_done_busy", if0.busy, 0);
                beats0 = 0;
            end
            if (if0.valid && if0.ready) begin
                chk_eq("d0_byte_expected", q0.size() != 0, 1);
                if (q0.size() != 0) chk_eq("d0_byte", if0.data, q0.pop_front());
                beats0++;
            end
            hold0 = if0.valid && !if0.ready; hdata0 = if0.data; dprev0 = if0.done;
        end
    end

    always @(negedge clock) begin
        if (!reset_n) begin
            beats1 = 0; hold1 = 1'b0; dprev1 = 1'b0;
        end else begin
            if (hold1) begin
                chk_eq("d1_hold_valid", if1.valid, 1);
                chk_eq("d1_hold_data", if1.data, hdata1);
            end
            if (if1.done) begin
                chk_eq("d1_done_width", dprev1, 0);
                chk_eq("d1_frame_len", beats1, 33);
                chk_eq("d1_done_valid", if1.valid, 0);
                chk_eq("d1_done_busy", if1.busy, 0);
                beats1 = 0;
            end
            if (if1.valid && if1.ready) begin
                chk_eq("d1_byte_expected", q1.size() != 0, 1);
                if (q1.size() != 0) chk_eq("d1_byte", if1.data, q1.pop_front());
                beats1++;
            end
            hold1 = if1.valid && !if1.ready; hdata1 = if1.data; dprev1 = if1.done;
        end
    end

    initial begin
        forever begin
            @(posedge clock);
            #2;
            if (rand_ready) ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; ready = 1'b1; rand_ready = 1'b0;
        utc = "123456."; day = "05"; month = "10"; year = "2021";
        #12;
        chk_eq("rst_busy",  {if0.busy,  if1.busy},  0);
        chk_eq("rst_valid", {if0.valid, if1.valid}, 0);
        chk_eq("rst_data",  {if0.data,  if1.data},  0);
        chk_eq("rst_done",  {if0.done,  if1.done},  0);
        chk_eq("rst_error", {if0.error, if1.error}, 0);
        tick();
        reset_n = 1'b1;

        // Reference frame, continuous ready.
        do_start(1'b1);
        chk_eq("lat_busy",  {if0.busy,  if1.busy},  2'b11);
        chk_eq("lat_valid", {if0.valid, if1.valid}, 2'b11);
        chk_eq("lat_data0", if0.data, 8'h24);
        chk_eq("lat_error", {if0.error, if1.error}, 0);
        wait_idle();

        // Back-pressure.
        rand_ready = 1'b1;
        do_start(1'b1);
        wait_idle();
        rand_ready = 1'b0;
        ready = 1'b1;

        // Start pulses and field changes mid-frame are ignored.
        do_start(1'b1);
        wait_beats(3);
        utc = "999999."; day = "31"; month = "12"; year = "1999";
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_beats(20);
        day = "7x";
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle();
        repeat (5) tick();
        chk_eq("no_2nd_valid", {if0.valid, if1.valid}, 0);
        chk_eq("no_2nd_busy",  {if0.busy,  if1.busy},  0);
        chk_eq("no_2nd_error", {if0.error, if1.error}, 0);
        utc = "123456."; day = "05"; month = "10"; year = "2021";

        // Non-digit day: flagged, frame still sent.
        day = "0A";
        do_start(1'b1);
        chk_eq("err_set", {if0.error, if1.error}, 2'b11);
        wait_idle();
        chk_eq("err_hold", {if0.error, if1.error}, 2'b11);
        day = "05";
        do_start(1'b1);
        chk_eq("err_clear", {if0.error, if1.error}, 0);
        wait_idle();

        // Reset mid-frame, then a fresh frame.
        do_start(1'b1);
        wait_beats(15);
        reset_n = 1'b0;
        #1;
        chk_eq("mid_rst_valid", {if0.valid, if1.valid}, 0);
        chk_eq("mid_rst_busy",  {if0.busy,  if1.busy},  0);
        chk_eq("mid_rst_done",  {if0.done,  if1.done},  0);
        chk_eq("mid_rst_data",  {if0.data,  if1.data},  0);
        q0.delete();
        q1.delete();
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        chk_eq("post_rst_done",  {if0.done,  if1.done},  0);
        chk_eq("post_rst_valid", {if0.valid, if1.valid}, 0);
        do_start(1'b1);
        chk_eq("post_rst_data0", if0.data, 8'h24);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gps_transmitter.md
# gps_transmitter

Serialises one GPZDA time/date record into an NMEA byte stream for a byte-wide UART transmitter. It is the sending-side counterpart of the GPZDA receiver. Fields are captured on a one-cycle `start` pulse. Bytes are then emitted one at a time on a valid/ready handshake, with an optional `*hh` XOR checksum and a CR LF terminator.

## Interface
- `B`, 8, bits per byte.
- `Separator`, `","`, field separator byte.
- `NoCheck`, 1'b0, 1 omits the `*hh` checksum suffix.
- `clock`  in  1  system clock, 100 MHz.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a frame; sampled only when `busy`=0.
- `utc`  in  7*B  UTC text, 7 bytes, most significant byte sent first, sent verbatim.
- `day`  in  2*B  two ASCII digits.
- `month`  in  2*B  two ASCII digits.
- `year`  in  4*B  four ASCII digits.
- `busy`  out  1  frame in progress.
- `valid`  out  1  `data` holds a byte to send.
- `ready`  in  1  sink accepts `data` this cycle.
- `data`  out  B  current byte.
- `done`  out  1  one-cycle pulse after the last byte is accepted.
- `error`  out  1  a non-digit byte was found in `day`, `month` or `year` of the current or last frame.

## Operation
- Frame layout: `$GPZDA` `,` utc(7) `,` dd `,` mm `,` yyyy `,00,00`, then `*` H L if `NoCheck`=0, then 0x0D 0x0A.
  - Length is 36 bytes with checksum, 33 without.
- States and transitions:
  - S_Idle → S_Prefix on `start`.
  - S_Prefix (7 bytes, including the separator) → S_UTC (7 bytes + separator) → S_Day (2 + separator) → S_Month (2 + separator) → S_Year (4) → S_Zone (`,00,00`, 6 bytes).
  - S_Zone → S_Check (3 bytes) if `NoCheck`=0, otherwise → S_Tail.
  - S_Check → S_Tail (CR, LF) → S_Idle.
- A byte index counter within each state advances only on `valid & ready`. The state changes when the last byte of the state is accepted.
- Checksum: 8-bit XOR of every byte after `$`, up to but excluding `*`. It is accumulated as bytes are accepted. Emitted as two uppercase ASCII hex digits, high nibble first.
- On `start` with `busy`=0:
  - all field inputs are latched into internal registers; later input changes do not affect the frame;
  - `error` is recomputed as 1 if any day/month/year byte lies outside 0x30..0x39. The frame is still sent unchanged.
- `start` while `busy`=1 is ignored. No queuing.
- `error` holds its value until the next accepted `start`.

## Timing
- Reset values: `busy`=0, `valid`=0, `data`=0, `done`=0, `error`=0; state S_Idle; checksum 0.
- Latency: `start` at edge k gives `busy`=1, `valid`=1, `data`=`$` from k+1. `data` and `valid` are registered.
- Handshake:
  - `data` stays stable while `valid & !ready`.
  - After an accepted byte, the next byte is presented in the following cycle. With `ready` held at 1, this gives 1 byte per clock with no bubbles.
  - `valid` never drops mid-frame.
- End of frame: on acceptance of LF, `valid`=0, `busy`=0 and `done`=1 all from the next cycle. `done` lasts exactly 1 cycle. A `start` in that same cycle is accepted.
- `reset_n` low mid-frame: all outputs return to their reset values immediately. No partial frame is resumed.

## Test plan
- Field inputs utc=`123456.`, day=`05`, month=`10`, year=`2021`; `ready`=1; `start` pulse → stream `$GPZDA,123456.,05,10,2021,00,00*64` CR LF. That is 36 consecutive valid cycles, then `done` for 1 cycle; `error`=0.
- Same fields with `NoCheck`=1 → 33 bytes ending `,00,00` 0x0D 0x0A, with no `*`.
- `ready` toggling pseudo-randomly → identical byte sequence; `data` never changes while `valid & !ready`.
- `start` pulses at bytes 3 and 20, and field inputs changed mid-frame → frame unaffected; no second frame.
- day=`0A` → `error`=1 from the cycle after `start` and the frame is still sent. A following `start` with valid fields → `error`=0.
- `reset_n` asserted at byte 15 → `valid`/`busy` drop immediately with no `done`. A new `start` after release → a full frame from `$`.
